uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter ADDR_W, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single system clock; all state SHALL be updated on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_dataIn  input  8  received byte from the UART receiver; stable while rx_doneTick is high.
REQ-006 rx_doneTick  input  1  byte-complete flag from the receiver; asynchronous to clk, may stay high for many clk cycles.
REQ-007 rd_en  input  1  consumer read request, one pop per cycle it is high.
REQ-008 rd_data  output  8  registered read data.
REQ-009 rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-010 empty  output  1  high when count == 0.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
REQ-013 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-014 clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-015 rx_doneTick SHALL pass through a 2-flop synchronizer (sync1, sync2), then a third flop (sync3); the write strobe SHALL be sync2 & ~sync3.
- Write strobe SHALL be high exactly one clk cycle per rising edge of rx_doneTick, no matter how long the input stays high.
REQ-016 Latency: rx_doneTick rises before edge N, so the write strobe is high in the cycle after edge N+1, and the byte SHALL be stored at edge N+2.
REQ-017 The write SHALL sample rx_dataIn directly, without synchronization, on the write-strobe edge.
REQ-018 Storage: DEPTH x 8 array, write pointer wp, read pointer rp, each ADDR_W bits.
- Both pointers SHALL wrap from DEPTH-1 to 0 with no extra logic.
REQ-019 Write accepted if write strobe & (~full | rd_en): mem[wp] <= rx_dataIn, wp increments.
REQ-020 Read accepted if rd_en & ~empty: rd_data <= mem[rp], rp increments, rd_valid <= 1 on the same edge.
- Otherwise rd_valid <= 0 and rd_data holds its value.
REQ-021 rd_en while empty SHALL be ignored: no pointer change, rd_valid 0, no error flag.
REQ-022 Write and read accepted in the same cycle: count SHALL be unchanged.
- Write only: count +1. Read only: count -1.
REQ-023 Full with write strobe and rd_en together: both SHALL be accepted, count stays DEPTH, overrun SHALL NOT set.
REQ-024 Empty with write strobe and rd_en together: only the write SHALL be accepted; the read is ignored, rd_valid 0, count becomes 1.
REQ-025 Write strobe while full and ~rd_en: byte dropped, memory and wp unchanged, overrun <= 1.
REQ-026 clr_overrun high: overrun <= 0, unless REQ-025 sets it in the same cycle; set SHALL win.
REQ-027 empty and full SHALL be decoded combinationally from count.
- count SHALL be a register, not derived from the pointers.
REQ-028 No combinational path from rd_en to rd_data or rd_valid.

Reset
REQ-029 While reset is high, asynchronously:
- wp, rp, count = 0; rd_data = 8'h00; rd_valid = 0; overrun = 0; sync1..sync3 = 0.
- Hence empty = 1 and full = 0.
REQ-030 Memory contents SHALL NOT be reset.
- Entries SHALL never be readable until written after reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored bytes and any in-flight synchronizer edge.
- A write strobe SHALL be generated after reset release only if rx_doneTick then shows a new 0 to 1 transition (REQ-015).
- An rx_doneTick already high at release SHALL NOT be treated as a new edge.

Verification
REQ-032 Hold rx_doneTick high 40 cycles, rx_dataIn=8'hA5: exactly one write; count=1 at edge N+2. Then rd_en one cycle: rd_data=8'hA5, rd_valid pulses once, empty=1.
REQ-033 Write bytes 0x00..0x0F (DEPTH=16): full=1, count=16. Then 17th byte 0x10 without rd_en: overrun=1, count=16. Read all 16: data 0x00..0x0F in order, then empty=1.
REQ-034 Full FIFO, rd_en in the same cycle as write strobe of 0x55: count stays 16, overrun=0. After draining, the last byte read is 0x55. Pointers wrap with no lost data.
REQ-035 Empty FIFO, rd_en held high continuously: rd_valid stays 0, count stays 0. Then one write of 0x3C: rd_valid pulses once with rd_data=0x3C, one cycle after the write edge.
REQ-036 overrun=1; clr_overrun with no drop: overrun=0 next edge. clr_overrun in the same cycle as a drop: overrun remains 1.
REQ-037 Assert reset with count=5 and a rx_doneTick edge in the synchronizer: all outputs at reset values immediately, no write after release. rx_doneTick high across reset release: no write until it falls and rises again.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between a UART receiver front end, the RX FIFO and its consumer.
// Latency: none (wiring only).
// Backpressure: none here; rd_en pops, and a full FIFO drops bytes and flags overrun.
// Ports (master side = producer/consumer, slave side = FIFO):
//   rx_dataIn/rx_doneTick : received byte and its completion flag (asynchronous to clk)
//   rd_en / clr_overrun   : consumer pop request, overrun clear
//   rd_data/rd_valid      : registered pop data and its one-cycle qualifier
//   empty/full/count/overrun : occupancy and sticky drop status
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      rx_dataIn;
    logic            rx_doneTick;
    logic            rd_en;
    logic            clr_overrun;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overrun;

    modport master (
        output rx_dataIn, rx_doneTick, rd_en, clr_overrun,
        input  rd_data, rd_valid, empty, full, count, overrun
    );

    modport slave (
        input  rx_dataIn, rx_doneTick, rd_en, clr_overrun,
        output rd_data, rd_valid, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: synchronizes rx_doneTick, stores one byte per rising edge.
// Latency: byte stored 2 edges after the first edge that sees rx_doneTick high; rd_data 1 edge after rd_en.
// Backpressure: none toward the receiver; a write into a full FIFO without a same-cycle pop is dropped and sets overrun.
// Ports: clk, reset (async, active-high); bus = uart_rx_fifo_if.slave (see interface header).
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic              sync1;
    logic              sync2;
    logic              sync3;
    // primed[2] is set once sync3 holds a genuinely sampled input value rather than
    // its reset zero; without it a rx_doneTick held high across reset release would
    // look like a fresh 0->1 edge.
    logic [2:0]        primed;
    logic              wr_stb;
    logic              wr_acc;
    logic              rd_acc;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W:0]   cnt;
    logic [7:0]        rd_data_q;
    logic              rd_valid_q;
    logic              overrun_q;
    logic              empty_c;
    logic              full_c;

    assign empty_c = (cnt == '0);
    assign full_c  = (cnt == DEPTH_C);

    assign wr_stb = sync2 & ~sync3 & primed[2];
    assign rd_acc = bus.rd_en & ~empty_c;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign wr_acc = wr_stb & (~full_c | bus.rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            primed <= '0;
        end else begin
            sync1  <= bus.rx_doneTick;
            sync2  <= sync1;
            sync3  <= sync2;
            primed <= {primed[1:0], 1'b1};
        end
    end

    // Storage is not reset; count/pointers guarantee nothing stale is ever popped.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= bus.rx_dataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wp <= wp + 1'b1;
            end

            // When full with a simultaneous write, wp == rp: the read sees the old entry.
            if (rd_acc) begin
                rd_data_q  <= mem[rp];
                rp         <= rp + 1'b1;
                rd_valid_q <= 1'b1;
            end else begin
                rd_valid_q <= 1'b0;
            end

            if (wr_acc && !rd_acc) begin
                cnt <= cnt + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                cnt <= cnt - 1'b1;
            end

            // A drop in the same cycle as a clear wins.
            if (wr_stb && full_c && !bus.rd_en) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_c;
    assign bus.full     = full_c;
    assign bus.count    = cnt;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed vector table, corner-case sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk;
    logic reset;

    uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A byte is stored at clock edge k (counted from 1 after reset release) when the
    // input was seen low at edge k-3 and high at edge k-2, and at least 3 real
    // samples exist; the stored value is rx_dataIn at edge k.
    bit       samp[$];
    byte      mq[$];
    bit       m_ovr;
    bit       m_vld;
    bit [7:0] m_data;

    always @(posedge clk or posedge reset) begin
        int  k;
        bit  wr;
        bit  was_full;
        bit  was_empty;
        if (reset) begin
            samp.delete();
            mq.delete();
            m_ovr  = 1'b0;
            m_vld  = 1'b0;
            m_data = 8'h00;
        end else begin
            k         = samp.size() + 1;
            wr        = (k >= 4) && samp[k-3] && !samp[k-4];
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (bus.rd_en && !was_empty) begin
                m_data = mq.pop_front();
                m_vld  = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            if (wr && (!was_full || bus.rd_en)) mq.push_back(bus.rx_dataIn);
            if (wr && was_full && !bus.rd_en) m_ovr = 1'b1;
            else if (bus.clr_overrun) m_ovr = 1'b0;
            samp.push_back(bus.rx_doneTick);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rd_valid", 32'(bus.rd_valid), 32'(m_vld));
            chk("m_rd_data",  32'(bus.rd_data),  32'(m_data));
            chk("m_count",    32'(bus.count),    32'(mq.size()));
            chk("m_empty",    32'(bus.empty),    32'(mq.size() == 0));
            chk("m_full",     32'(bus.full),     32'(mq.size() == DEPTH));
            chk("m_overrun",  32'(bus.overrun),  32'(m_ovr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_dataIn   = b;
        bus.rx_doneTick = 1'b1;
        step(3);
        bus.rx_doneTick = 1'b0;
        step(2);
    endtask

    typedef struct {
        logic       dt;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        int         n;
        int         exp_count;
        logic       exp_vld;
        logic [7:0] exp_data;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[12];
    byte  exp_drain[16];

    initial begin
        int hi_left;
        int lo_left;
        int rd_pct;

        // Long-held done tick: one write at N+2, then one read.
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0,  4, 0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0,  1, 0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0,  1, 0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0,  1, 1, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 37, 1, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 8'hA5, 1'b1, 1'b0,  1, 0, 1'b1, 8'hA5, 1'b0};
        tbl[6]  = '{1'b0, 8'hA5, 1'b0, 1'b0,  1, 0, 1'b0, 8'hA5, 1'b0};
        // rd_en held on an empty FIFO, then one write is popped the next edge.
        tbl[7]  = '{1'b0, 8'hA5, 1'b1, 1'b0,  5, 0, 1'b0, 8'hA5, 1'b0};
        tbl[8]  = '{1'b1, 8'h3C, 1'b1, 1'b0,  2, 0, 1'b0, 8'hA5, 1'b0};
        tbl[9]  = '{1'b1, 8'h3C, 1'b1, 1'b0,  1, 1, 1'b0, 8'hA5, 1'b0};
        tbl[10] = '{1'b1, 8'h3C, 1'b1, 1'b0,  1, 0, 1'b1, 8'h3C, 1'b0};
        tbl[11] = '{1'b0, 8'h3C, 1'b0, 1'b0,  3, 0, 1'b0, 8'h3C, 1'b0};

        for (int i = 0; i < 15; i++) exp_drain[i] = byte'(i + 1);
        exp_drain[15] = 8'h55;

        bus.rx_dataIn   = 8'h00;
        bus.rx_doneTick = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;
        reset           = 1'b1;
        #2;
        chk_en = 1'b1;
        chk("reset_count",    32'(bus.count),    32'd0);
        chk("reset_empty",    32'(bus.empty),    32'd1);
        chk("reset_full",     32'(bus.full),     32'd0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_rd_data",  32'(bus.rd_data),  32'd0);
        chk("reset_overrun",  32'(bus.overrun),  32'd0);
        step(3);
        reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++) begin
            bus.rx_doneTick = tbl[i].dt;
            bus.rx_dataIn   = tbl[i].din;
            bus.rd_en       = tbl[i].rd;
            bus.clr_overrun = tbl[i].clr;
            step(tbl[i].n);
            chk($sformatf("vec%0d_count", i),    32'(bus.count),    32'(tbl[i].exp_count));
            chk($sformatf("vec%0d_empty", i),    32'(bus.empty),    32'(tbl[i].exp_count == 0));
            chk($sformatf("vec%0d_rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].exp_vld));
            chk($sformatf("vec%0d_rd_data", i),  32'(bus.rd_data),  32'(tbl[i].exp_data));
            chk($sformatf("vec%0d_overrun", i),  32'(bus.overrun),  32'(tbl[i].exp_ovr));
        end
        bus.rd_en = 1'b0;

        // ---------------- fill, overrun, clear ----------------
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        send_byte(8'h10);
        chk("drop_overrun", 32'(bus.overrun), 32'd1);
        chk("drop_count",   32'(bus.count),   32'd16);

        bus.clr_overrun = 1'b1;
        step(1);
        bus.clr_overrun = 1'b0;
        chk("clr_overrun", 32'(bus.overrun), 32'd0);

        // Clear asserted exactly on the dropping edge: set must win.
        bus.rx_dataIn   = 8'h11;
        bus.rx_doneTick = 1'b1;
        step(2);
        bus.clr_overrun = 1'b1;
        step(1);
        bus.clr_overrun = 1'b0;
        bus.rx_doneTick = 1'b0;
        chk("set_wins_overrun", 32'(bus.overrun), 32'd1);
        step(2);
        bus.clr_overrun = 1'b1;
        step(1);
        bus.clr_overrun = 1'b0;
        chk("clr2_overrun", 32'(bus.overrun), 32'd0);

        // Full FIFO, pop on the strobe edge of 0x55.
        bus.rx_dataIn   = 8'h55;
        bus.rx_doneTick = 1'b1;
        step(2);
        bus.rd_en = 1'b1;
        step(1);
        bus.rd_en       = 1'b0;
        bus.rx_doneTick = 1'b0;
        chk("fullrw_count",    32'(bus.count),    32'd16);
        chk("fullrw_overrun",  32'(bus.overrun),  32'd0);
        chk("fullrw_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("fullrw_rd_data",  32'(bus.rd_data),  32'h00);
        step(2);

        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk($sformatf("drain%0d_rd_valid", i), 32'(bus.rd_valid), 32'd1);
            chk($sformatf("drain%0d_rd_data", i),  32'(bus.rd_data),  32'(exp_drain[i]));
        end
        bus.rd_en = 1'b0;
        step(1);
        chk("drained_empty",    32'(bus.empty),    32'd1);
        chk("drained_rd_valid", 32'(bus.rd_valid), 32'd0);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
        chk("pre_reset_count", 32'(bus.count), 32'd5);
        bus.rx_dataIn   = 8'h77;
        bus.rx_doneTick = 1'b1;
        step(1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_count",    32'(bus.count),    32'd0);
        chk("async_reset_empty",    32'(bus.empty),    32'd1);
        chk("async_reset_full",     32'(bus.full),     32'd0);
        chk("async_reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("async_reset_rd_data",  32'(bus.rd_data),  32'd0);
        bus.rx_doneTick = 1'b0;
        step(2);
        reset = 1'b0;
        step(6);
        chk("inflight_discarded_count", 32'(bus.count), 32'd0);

        bus.rx_doneTick = 1'b1;
        bus.rx_dataIn   = 8'h9A;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        chk("high_at_release_count", 32'(bus.count), 32'd0);
        bus.rx_doneTick = 1'b0;
        step(2);
        bus.rx_doneTick = 1'b1;
        step(3);
        chk("new_edge_count", 32'(bus.count), 32'd1);
        bus.rx_doneTick = 1'b0;
        bus.rd_en       = 1'b1;
        step(1);
        bus.rd_en = 1'b0;
        chk("new_edge_rd_data", 32'(bus.rd_data), 32'h9A);
        step(2);

        // ---------------- randomized run against the model ----------------
        hi_left = 0;
        lo_left = 2;
        for (int c = 0; c < 3000; c++) begin
            rd_pct = ((c / 400) % 2 == 1) ? 60 : 12;
            if (bus.rx_doneTick) begin
                if (hi_left == 0) begin
                    bus.rx_doneTick = 1'b0;
                    lo_left = $urandom_range(1, 4);
                end else begin
                    hi_left--;
                end
            end else begin
                if (lo_left == 0) begin
                    bus.rx_doneTick = 1'b1;
                    bus.rx_dataIn   = 8'($urandom);
                    hi_left = $urandom_range(0, 5);
                end else begin
                    lo_left--;
                end
            end
            bus.rd_en       = ($urandom_range(0, 99) < rd_pct);
            bus.clr_overrun = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end else begin
                step(1);
            end
        end
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;
        bus.rx_doneTick = 1'b0;
        step(4);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
